// File: rtl/aud_fir_pkg.sv
// Shared definitions for the CIC droop-compensation FIR: FSM states, clog2 helper
// and the symmetric inverse-sinc^5 coefficient table.
package aud_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_t;

  // Outer half of the 32-tap prototype, index 15 is next to the centre.
  // Full-table sum is 137840, slightly above unity gain (131072).
  localparam int COEF_HALF [16] = '{
    -20, 30, -45, 60, -85, 120, -170, 240,
    -340, 480, -700, 1050, -1700, 3000, -7000, 74000
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Mirror k into the first half, then stretch the 16-entry prototype over
  // TAPS/2 entries measured from the centre so every length stays symmetric.
  function automatic int coef_at(input int k, input int taps);
    int half, j, d, idx;
    half = taps / 2;
    j    = (k < half) ? k : (taps - 1 - k);
    d    = half - 1 - j;
    idx  = 15 - (d * 16) / half;
    return COEF_HALF[idx];
  endfunction

endpackage

// File: rtl/aud_fir_mac.sv
// Registered signed multiply-accumulate: acc <= (clr ? 0 : acc) + a*b when en.
module aud_fir_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 42
) (
  input  logic                     CLK,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int P_W = DATA_W + COEF_W;

  logic signed [P_W-1:0]   prod_p0;
  logic signed [ACC_W-1:0] prod_ext_p0;

  assign prod_p0     = a * b;
  assign prod_ext_p0 = {{(ACC_W - P_W){prod_p0[P_W-1]}}, prod_p0};

  // p0 -> p1: accumulator register
  always_ff @(posedge CLK) begin
    if (en) acc <= clr ? prod_ext_p0 : (acc + prod_ext_p0);
  end

endmodule

// File: rtl/aud_cic_comp_fir.sv
// Decimating CIC droop-compensation FIR with one time-shared multiplier.
// Define AUD_CIC_COMP_SAT_EN to clamp the rounded result instead of wrapping it.
module aud_cic_comp_fir
  import aud_fir_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int TAPS      = 32,
  parameter int DECIM     = 2,
  parameter int COEF_BITS = 18,
  parameter int COEF_FRAC = 17,
  parameter int ACC_BITS  = 42
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic            in_tick,
  input  logic [BITS-1:0] x_in,
  output logic [BITS-1:0] x_out,
  output logic            out_tick,
  output logic            busy,
  output logic            overrun
);

  localparam int AW = clog2(TAPS);
  localparam int PW = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam logic signed [ACC_BITS-1:0] RND_C = ACC_BITS'(1) << (COEF_FRAC - 1);
`ifdef AUD_CIC_COMP_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = (ACC_BITS'(1) << (BITS - 1)) - ACC_BITS'(1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = -(ACC_BITS'(1) << (BITS - 1));
`endif

  fir_state_t state, state_nx;
  logic [AW-1:0] wr_ptr, base, k, rd_idx;
  logic [PW-1:0] phase;
  logic [TAPS-1:0] vld_mask;
  logic signed [BITS-1:0]      buf_mem [TAPS];
  logic signed [COEF_BITS-1:0] coef_rom [TAPS];
  logic signed [BITS-1:0]      smp_p0;
  logic signed [ACC_BITS-1:0]  acc_p1;
  logic trig, core_busy, accept, mac_en, mac_clr;

  function automatic logic signed [BITS-1:0] round_out(input logic signed [ACC_BITS-1:0] a);
`ifdef AUD_CIC_COMP_SAT_EN
    logic signed [ACC_BITS-1:0] r;
    r = (a + RND_C) >>> COEF_FRAC;
    if (r > SAT_MAX)      round_out = SAT_MAX[BITS-1:0];
    else if (r < SAT_MIN) round_out = SAT_MIN[BITS-1:0];
    else                  round_out = r[BITS-1:0];
`else
    round_out = BITS'((a + RND_C) >>> COEF_FRAC);
`endif
  endfunction

  for (genvar g = 0; g < TAPS; g++) begin : g_coef
    assign coef_rom[g] = COEF_BITS'(coef_at(g, TAPS));
  end

  assign trig      = in_tick && (phase == PW'(DECIM - 1));
  // A trigger in the OUT cycle is accepted; only MAC/ROUND make it an overrun.
  assign core_busy = (state == ST_MAC) || (state == ST_ROUND);
  assign accept    = trig && !core_busy;
  assign busy      = (state != ST_IDLE);
  assign mac_en    = (state == ST_MAC);
  assign mac_clr   = mac_en && (k == '0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_MAC;
      ST_MAC:   if (k == AW'(TAPS - 1)) state_nx = ST_ROUND;
      ST_ROUND: state_nx = ST_OUT;
      ST_OUT:   state_nx = accept ? ST_MAC : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      phase    <= '0;
      base     <= '0;
      k        <= '0;
      vld_mask <= '0;
      overrun  <= 1'b0;
      out_tick <= 1'b0;
      x_out    <= '0;
    end else begin
      state    <= state_nx;
      out_tick <= (state == ST_ROUND);
      if (state == ST_ROUND) x_out <= round_out(acc_p1);
      if (in_tick) begin
        wr_ptr           <= wr_ptr + 1'b1;
        vld_mask[wr_ptr] <= 1'b1;
        phase            <= trig ? '0 : (phase + 1'b1);
        if (core_busy) overrun <= 1'b1;
      end
      if (accept) begin
        base <= wr_ptr;
        k    <= '0;
      end else if (state == ST_MAC) begin
        k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (in_tick) buf_mem[wr_ptr] <= $signed(x_in);
  end

  // p0: sample fetch, never-written slots read as zero
  assign rd_idx = base - k;
  assign smp_p0 = vld_mask[rd_idx] ? buf_mem[rd_idx] : '0;

  aud_fir_mac #(
    .DATA_W(BITS),
    .COEF_W(COEF_BITS),
    .ACC_W (ACC_BITS)
  ) u_mac (
    .CLK(CLK),
    .clr(mac_clr),
    .en (mac_en),
    .a  (smp_p0),
    .b  (coef_rom[k]),
    .acc(acc_p1)
  );

endmodule

// File: tb/tb_aud_cic_comp_fir.sv
// Bench for aud_cic_comp_fir: DECIM=2 and DECIM=1 instances share one input stream.
module tb_aud_cic_comp_fir;
  import aud_fir_pkg::*;

  localparam int TAPS = 32;
  localparam int FRAC = 17;
  localparam int DEC [2] = '{2, 1};

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        in_tick;
  logic [15:0] x_in;
  logic [15:0] xo [2];
  logic        ot [2];
  logic        bz [2];
  logic        ov [2];

  aud_cic_comp_fir #(.DECIM(2)) dut0 (
    .CLK(CLK), .RSTb(RSTb), .in_tick(in_tick), .x_in(x_in),
    .x_out(xo[0]), .out_tick(ot[0]), .busy(bz[0]), .overrun(ov[0])
  );
  aud_cic_comp_fir #(.DECIM(1)) dut1 (
    .CLK(CLK), .RSTb(RSTb), .in_tick(in_tick), .x_in(x_in),
    .x_out(xo[1]), .out_tick(ot[1]), .busy(bz[1]), .overrun(ov[1])
  );

  always #5 CLK = ~CLK;

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input int inst, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, inst, act, req);
    end
  endtask

  // Final output stage of the model: clamp or two's-complement wrap to 16 bits.
  function automatic longint limit16(input longint r);
    longint w;
`ifdef AUD_CIC_COMP_SAT_EN
    w = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
`else
    w = r & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
`endif
    return w;
  endfunction

  function automatic longint round_frac(input longint acc);
    return (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
  endfunction

  // Reference model state: last TAPS samples since reset, newest at the back.
  int     hist [$];
  int     phs [2];
  longint acc_c [2];
  bit     ovr [2];
  bit     dirty [2];
  longint exp_val [2];
  int     ot_cnt [2];
  int     acc_cnt [2];
  longint dt;
  bit     core, trg;

  function automatic longint model_out();
    longint acc;
    int n;
    acc = 0;
    n = hist.size();
    for (int k = 0; k < TAPS; k++)
      if (k < n) acc += longint'(hist[n - 1 - k]) * longint'(coef_at(k, TAPS));
    return limit16(round_frac(acc));
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      phs[i] = 0; acc_c[i] = -1000; ovr[i] = 1'b0; dirty[i] = 1'b0; exp_val[i] = 0;
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 2; i++) begin ot_cnt[i] = 0; acc_cnt[i] = 0; end
  end

  always @(negedge CLK) begin
    if (!RSTb) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        dt = cyc - acc_c[i];
        check("busy", i, longint'(bz[i]), longint'(dt >= 1 && dt <= TAPS + 2));
        check("overrun", i, longint'(ov[i]), longint'(ovr[i]));
        if (ot[i]) ot_cnt[i]++;
        if (ot[i] || dt == TAPS + 2) check("out_tick", i, longint'(ot[i]), longint'(dt == TAPS + 2));
        if (dt == TAPS + 2 && !dirty[i]) check("x_out", i, longint'($signed(xo[i])), exp_val[i]);
      end
      if (in_tick) begin
        hist.push_back(int'($signed(x_in)));
        if (hist.size() > TAPS) void'(hist.pop_front());
        for (int i = 0; i < 2; i++) begin
          dt   = cyc - acc_c[i];
          core = (dt >= 1 && dt <= TAPS + 1);
          trg  = (phs[i] == DEC[i] - 1);
          phs[i] = trg ? 0 : phs[i] + 1;
          if (core) begin ovr[i] = 1'b1; dirty[i] = 1'b1; end
          if (trg && !core) begin
            acc_c[i] = cyc; dirty[i] = 1'b0; exp_val[i] = model_out(); acc_cnt[i]++;
          end
        end
      end
    end
  end

  typedef struct {
    logic [15:0] x;
    longint      exp;
  } vec_t;
  vec_t tbl [TAPS];

  task automatic send(input logic [15:0] v, input int gap);
    @(posedge CLK); #1;
    in_tick = 1'b1; x_in = v;
    @(posedge CLK); #1;
    in_tick = 1'b0; x_in = 16'h0000;
    repeat (gap - 1) @(posedge CLK);
  endtask

  task automatic run_impulse();
    int w;
    for (int k = 0; k < TAPS; k++) begin
      send(tbl[k].x, 1);
      w = 0;
      while (!ot[1] && w < 60) begin @(negedge CLK); w++; end
      if (w < 60) check("impulse", k, longint'($signed(xo[1])), tbl[k].exp);
      else        check("impulse_timeout", k, longint'(w), 0);
    end
    repeat (2) @(posedge CLK);
  endtask

  longint csum, r, d;
  int     o0, a0, o1, a1;

  initial begin
    RSTb = 1'b0; in_tick = 1'b0; x_in = 16'h0000;
    csum = 0;
    for (int k = 0; k < TAPS; k++) begin
      csum += coef_at(k, TAPS);
      tbl[k].x   = (k == 0) ? 16'd16384 : 16'd0;
      tbl[k].exp = limit16(round_frac(longint'(16384) * coef_at(k, TAPS)));
    end
    repeat (3) @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_x_out", i, longint'(xo[i]), 0);
      check("rst_out_tick", i, longint'(ot[i]), 0);
      check("rst_busy", i, longint'(bz[i]), 0);
      check("rst_overrun", i, longint'(ov[i]), 0);
    end
    RSTb = 1'b1;

    run_impulse();

    o0 = ot_cnt[0];
    for (int n = 0; n < 2 * TAPS; n++) send(16'd1000, 40);
    check("dc_ticks", 0, longint'(ot_cnt[0] - o0), TAPS);
    d = longint'($signed(xo[0])) - limit16(round_frac(1000 * csum));
    check("dc_steady", 0, longint'(d >= -1 && d <= 1), 1);

    o0 = ot_cnt[0];
    for (int n = 0; n < 20; n++) send(16'(n * 37 - 300), 100);
    check("latency_ticks", 0, longint'(ot_cnt[0] - o0), 10);

    for (int n = 0; n < 2 * TAPS; n++) send(16'd32767, 40);
    r = limit16(round_frac(32767 * csum));
    check("saturation", 0, longint'($signed(xo[0])), r);
    check("saturation", 1, longint'($signed(xo[1])), r);

    o0 = ot_cnt[0]; a0 = acc_cnt[0]; o1 = ot_cnt[1]; a1 = acc_cnt[1];
    for (int n = 0; n < 200; n++) send(16'($urandom), $urandom_range(60, 1));
    repeat (40) @(posedge CLK);
    check("random_ticks", 0, longint'(ot_cnt[0] - o0), longint'(acc_cnt[0] - a0));
    check("random_ticks", 1, longint'(ot_cnt[1] - o1), longint'(acc_cnt[1] - a1));

    o0 = ot_cnt[0]; a0 = acc_cnt[0]; o1 = ot_cnt[1]; a1 = acc_cnt[1];
    for (int n = 0; n < 40; n++) send(16'($urandom_range(2000, 0)), 5);
    repeat (40) @(posedge CLK); #1;
    check("ovr_ticks", 0, longint'(ot_cnt[0] - o0), longint'(acc_cnt[0] - a0));
    check("ovr_ticks", 1, longint'(ot_cnt[1] - o1), longint'(acc_cnt[1] - a1));
    check("ovr_sticky", 0, longint'(ov[0]), 1);
    check("ovr_sticky", 1, longint'(ov[1]), 1);

    send(16'h1234, 1);
    repeat (10) @(posedge CLK);
    #2 RSTb = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midmac_x_out", i, longint'(xo[i]), 0);
      check("midmac_out_tick", i, longint'(ot[i]), 0);
      check("midmac_busy", i, longint'(bz[i]), 0);
      check("midmac_overrun", i, longint'(ov[i]), 0);
    end
    repeat (3) @(posedge CLK); #1;
    RSTb = 1'b1;
    o0 = ot_cnt[0]; o1 = ot_cnt[1];
    repeat (50) @(posedge CLK);
    check("midmac_no_tick", 0, longint'(ot_cnt[0] - o0), 0);
    check("midmac_no_tick", 1, longint'(ot_cnt[1] - o1), 0);

    run_impulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
